// File: rtl/galaksija_serkbd_queue_if.sv
// Bus bundle between the serial-keyboard queue and its surroundings:
// UART receive side, flush strobe and the CPU keyboard-matrix read port.
interface galaksija_serkbd_queue_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       starting;
    logic [5:0] key_addr;
    logic       rd_key;
    logic [7:0] key_out;
    logic       fifo_full;
    logic       busy;
    logic       overflow;

    // Driver side: UART receiver and CPU decode.
    modport master (
        output rx_data, rx_valid, starting, key_addr, rd_key,
        input  key_out, fifo_full, busy, overflow
    );

    // Keyboard queue side.
    modport slave (
        input  rx_data, rx_valid, starting, key_addr, rd_key,
        output key_out, fifo_full, busy, overflow
    );
endinterface

// File: rtl/galaksija_serkbd_queue.sv
// Serial keyboard queue for the Galaksija: UART bytes are translated into
// keyboard-matrix indices, buffered in a small FIFO and replayed one by one
// as timed key presses (optional SHIFT lead, hold, release gap) so that the
// 50 Hz keyboard scan sees every character. Exposes the 64-key matrix read
// port used by the CPU keyboard window.
module galaksija_serkbd_queue #(
    parameter int FIFO_AW     = 4,
    parameter int CNT_W       = 24,
    parameter int SHIFT_LEAD  = 500000,
    parameter int HOLD_CYCLES = 1500000,
    parameter int GAP_CYCLES  = 1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    galaksija_serkbd_queue_if.slave    bus
);
    localparam int PW        = FIFO_AW + 1;
    localparam int DEPTH     = 1 << FIFO_AW;
    localparam int SHIFT_KEY = 53;
    localparam int NULL_KEY  = 63;

    localparam logic [CNT_W-1:0] LEAD_LOAD = CNT_W'(SHIFT_LEAD - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LEAD, HOLD, GAP} state_t;

    // ------------------------------------------------------------------
    // Byte -> {valid, shift, idx} translation
    // ------------------------------------------------------------------
    logic [7:0] rx_byte;
    logic       tr_valid;
    logic       tr_shift;
    logic [5:0] tr_idx;

    assign rx_byte = bus.rx_data;

    // Map a received ASCII byte onto the Galaksija key matrix.
    always_comb begin
        tr_valid = 1'b1;
        tr_shift = 1'b0;
        tr_idx   = 6'd0;
        if (rx_byte inside {[8'h41:8'h5A]}) begin
            tr_idx = 6'(rx_byte - 8'h40);
        end else if (rx_byte inside {[8'h61:8'h7A]}) begin
            tr_idx = 6'(rx_byte - 8'h60);
        end else if (rx_byte inside {[8'h30:8'h39]}) begin
            tr_idx = 6'd32 + 6'(rx_byte - 8'h30);
        end else begin
            case (rx_byte)
                8'h0D, 8'h0A: tr_idx = 6'd48;
                8'h08, 8'h7F: tr_idx = 6'd29;
                8'h1B:        tr_idx = 6'd49;
                8'h20:        tr_idx = 6'd31;
                // Shifted symbols on the digit row
                8'h5F: begin tr_shift = 1'b1; tr_idx = 6'd32; end // _
                8'h21: begin tr_shift = 1'b1; tr_idx = 6'd33; end // !
                8'h22: begin tr_shift = 1'b1; tr_idx = 6'd34; end // "
                8'h23: begin tr_shift = 1'b1; tr_idx = 6'd35; end // #
                8'h24: begin tr_shift = 1'b1; tr_idx = 6'd36; end // $
                8'h25: begin tr_shift = 1'b1; tr_idx = 6'd37; end // %
                8'h26: begin tr_shift = 1'b1; tr_idx = 6'd38; end // &
                8'h5C: begin tr_shift = 1'b1; tr_idx = 6'd39; end // backslash
                8'h28: begin tr_shift = 1'b1; tr_idx = 6'd40; end // (
                8'h29: begin tr_shift = 1'b1; tr_idx = 6'd41; end // )
                8'h2B: begin tr_shift = 1'b1; tr_idx = 6'd42; end // +
                8'h2A: begin tr_shift = 1'b1; tr_idx = 6'd43; end // *
                8'h3C: begin tr_shift = 1'b1; tr_idx = 6'd44; end // <
                8'h2D: begin tr_shift = 1'b1; tr_idx = 6'd45; end // -
                8'h3E: begin tr_shift = 1'b1; tr_idx = 6'd46; end // >
                8'h3F: begin tr_shift = 1'b1; tr_idx = 6'd47; end // ?
                // Unshifted punctuation sharing those keys
                8'h3B: tr_idx = 6'd42; // ;
                8'h3A: tr_idx = 6'd43; // :
                8'h2C: tr_idx = 6'd44; // ,
                8'h3D: tr_idx = 6'd45; // =
                8'h2E: tr_idx = 6'd46; // .
                8'h2F: tr_idx = 6'd47; // /
                default: tr_valid = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Flush detection and FIFO control
    // ------------------------------------------------------------------
    logic          starting_q_reg;
    logic          flush;
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic          fifo_empty, fifo_full_int;
    logic          pop, push_req, push_ok;
    logic          overflow_reg;
    logic [6:0]    mem [DEPTH];
    logic [6:0]    head;
    state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [6:0]    cur_reg;

    assign flush         = bus.starting && !starting_q_reg;
    assign fifo_empty    = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full_int = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                           (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
    // The FSM consumes the head directly in IDLE, so the head is read
    // combinationally; the queue is tiny and maps to distributed storage.
    assign head          = mem[rd_ptr_reg[FIFO_AW-1:0]];
    assign pop           = (state_reg == IDLE) && !fifo_empty && !flush;
    assign push_req      = bus.rx_valid && tr_valid && !flush;
    // A simultaneous pop frees a slot, so a full FIFO still accepts the byte.
    assign push_ok       = push_req && (!fifo_full_int || pop);

    // Previous value of starting, for rising-edge detection (sampled in reset too).
    always_ff @(posedge clk) begin
        starting_q_reg <= bus.starting;
    end

    // Queue storage write port.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[FIFO_AW-1:0]] <= {tr_shift, tr_idx};
        end
    end

    // FIFO pointers and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push_req && !push_ok) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Replay FSM
    // ------------------------------------------------------------------
    // State, counter and current-entry registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            cur_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (pop) begin
                cur_reg <= head;
            end
        end
    end

    // Next-state logic: lead (shift only), hold, release gap, back to idle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        if (head[6]) begin
                            state_next = LEAD;
                            cnt_next   = LEAD_LOAD;
                        end else begin
                            state_next = HOLD;
                            cnt_next   = HOLD_LOAD;
                        end
                    end
                end
                LEAD: begin
                    if (cnt_reg == '0) begin
                        state_next = HOLD;
                        cnt_next   = HOLD_LOAD;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt_reg == '0) begin
                        state_next = GAP;
                        cnt_next   = GAP_LOAD;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_reg == '0) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pressed-key set and matrix read port
    // ------------------------------------------------------------------
    logic        shift_down, key_down;
    logic [63:0] key_pressed;
    logic [7:0]  key_out_reg;

    assign shift_down = (state_reg == LEAD) || ((state_reg == HOLD) && cur_reg[6]);
    assign key_down   = (state_reg == HOLD);

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_key
            if (gi == NULL_KEY) begin : g_null
                assign key_pressed[gi] = 1'b0;
            end else if (gi == SHIFT_KEY) begin : g_shift
                assign key_pressed[gi] = shift_down || (key_down && (cur_reg[5:0] == 6'(gi)));
            end else begin : g_plain
                assign key_pressed[gi] = key_down && (cur_reg[5:0] == 6'(gi));
            end
        end
    endgenerate

    // Registered matrix read; a flush releases the visible key immediately.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            key_out_reg <= 8'hFF;
        end else if (bus.rd_key) begin
            key_out_reg <= key_pressed[bus.key_addr] ? 8'hFE : 8'hFF;
        end
    end

    assign bus.key_out   = key_out_reg;
    assign bus.fifo_full = fifo_full_int;
    assign bus.busy      = (state_reg != IDLE) || !fifo_empty;
    assign bus.overflow  = overflow_reg;
endmodule
